// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and helper predicates for alu_mdu.
// ALU_MDU_DIV_EN adds the DIV state and makes DIV/DIVU multi-cycle.
package alu_pkg;

    typedef enum logic [3:0] {
        EXE_ALU_ADD   = 4'd0,
        EXE_ALU_SUB   = 4'd1,
        EXE_ALU_SLT   = 4'd2,
        EXE_ALU_AND   = 4'd3,
        EXE_ALU_OR    = 4'd4,
        EXE_ALU_SLL   = 4'd5,
        EXE_ALU_SRL   = 4'd6,
        EXE_ALU_LUI   = 4'd7,
        EXE_ALU_XOR   = 4'd8,
        EXE_ALU_NOR   = 4'd9,
        EXE_ALU_SLTU  = 4'd10,
        EXE_ALU_SRA   = 4'd11,
        EXE_ALU_MULT  = 4'd12,
        EXE_ALU_MULTU = 4'd13,
        EXE_ALU_DIV   = 4'd14,
        EXE_ALU_DIVU  = 4'd15
    } alu_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
`ifdef ALU_MDU_DIV_EN
        ST_DIV,
`endif
        ST_FIX,
        ST_DONE
    } state_t;

    function automatic logic is_div(input alu_op_t op);
        return (op == EXE_ALU_DIV) || (op == EXE_ALU_DIVU);
    endfunction

    function automatic logic is_multi(input alu_op_t op);
        logic m;
        m = (op == EXE_ALU_MULT) || (op == EXE_ALU_MULTU);
`ifdef ALU_MDU_DIV_EN
        m = m || is_div(op);
`endif
        return m;
    endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// alu_mdu_if: request/response bundle between EX control and alu_mdu.
// ALU_MDU_DIV_EN does not change this interface.
interface alu_mdu_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       oper;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;

    modport master (
        output in_valid, oper, a, b, flush,
        input  in_ready, out_valid, result, hi, lo, busy
    );

    modport slave (
        input  in_valid, oper, a, b, flush,
        output in_ready, out_valid, result, hi, lo, busy
    );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: radix-2 shift/add multiplier and restoring divider.
// The divider datapath exists only with ALU_MDU_DIV_EN defined.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start_mul,
`ifdef ALU_MDU_DIV_EN
    input  logic             i_start_div,
`endif
    input  logic             i_signed,
    input  logic             i_run,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_last,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);
    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_hi, r_lo, r_op;
    logic               r_neg_q;
    logic               w_start, w_sa, w_sb;
    logic [WIDTH-1:0]   w_ma, w_mb;
    logic [WIDTH:0]     w_madd;
    logic [2*WIDTH-1:0] w_prod;

    assign w_sa   = i_signed & i_a[WIDTH-1];
    assign w_sb   = i_signed & i_b[WIDTH-1];
    assign w_ma   = w_sa ? -i_a : i_a;
    assign w_mb   = w_sb ? -i_b : i_b;
    assign w_madd = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_op} : '0);
    assign w_prod = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign o_last = i_run && (r_cnt == CW'(WIDTH - 1));

`ifdef ALU_MDU_DIV_EN
    logic           r_div, r_neg_r;
    logic [WIDTH:0] w_shr, w_trial;

    assign w_start = i_start_mul | i_start_div;
    assign w_shr   = {r_hi, r_lo[WIDTH-1]};
    assign w_trial = w_shr - {1'b0, r_op};

    always_comb begin
        o_hi = w_prod[2*WIDTH-1:WIDTH];
        o_lo = w_prod[WIDTH-1:0];
        if (r_div) begin
            o_lo = r_neg_q ? -r_lo : r_lo;
            o_hi = r_neg_r ? -r_hi : r_hi;
        end
    end
`else
    assign w_start = i_start_mul;
    assign o_hi    = w_prod[2*WIDTH-1:WIDTH];
    assign o_lo    = w_prod[WIDTH-1:0];
`endif

    // hi accumulates product/remainder, lo holds multiplier/quotient bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_op    <= '0;
            r_neg_q <= 1'b0;
`ifdef ALU_MDU_DIV_EN
            r_div   <= 1'b0;
            r_neg_r <= 1'b0;
`endif
        end else if (w_start) begin
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= w_ma;
            r_op    <= w_mb;
            r_neg_q <= w_sa ^ w_sb;
`ifdef ALU_MDU_DIV_EN
            r_div   <= i_start_div;
            r_neg_r <= w_sa;
`endif
        end else if (i_run) begin
            r_cnt <= r_cnt + 1'b1;
`ifdef ALU_MDU_DIV_EN
            if (r_div) begin
                if (!w_trial[WIDTH]) begin
                    r_hi <= w_trial[WIDTH-1:0];
                    r_lo <= {r_lo[WIDTH-2:0], 1'b1};
                end else begin
                    r_hi <= w_shr[WIDTH-1:0];
                    r_lo <= {r_lo[WIDTH-2:0], 1'b0};
                end
            end else
`endif
            begin
                r_hi <= w_madd[WIDTH:1];
                r_lo <= {w_madd[0], r_lo[WIDTH-1:1]};
            end
        end
    end
endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: EX-stage ALU with iterative MULT/MULTU and optional DIV/DIVU.
// Define ALU_MDU_DIV_EN to build the divider; otherwise DIV/DIVU give 0.
module alu_mdu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    alu_mdu_if.slave  bus
);
    localparam int SW = $clog2(WIDTH);

    state_t           r_state, w_state_n;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_result, r_hi, r_lo;
    alu_op_t          w_op;
    logic             w_accept, w_single, w_start_mul, w_signed;
    logic             w_run, w_last;
    logic [SW-1:0]    w_sh;
    logic [WIDTH-1:0] w_alu, w_fix_hi, w_fix_lo;

    assign w_op         = alu_op_t'(bus.oper);
    assign w_sh         = bus.a[SW-1:0];
    assign bus.in_ready = (r_state == ST_IDLE) && !bus.flush;
    assign w_accept     = bus.in_valid && bus.in_ready;
    assign w_single     = w_accept && !is_multi(w_op);
    assign w_start_mul  = w_accept &&
                          ((w_op == EXE_ALU_MULT) || (w_op == EXE_ALU_MULTU));

`ifdef ALU_MDU_DIV_EN
    logic w_start_div, w_div0;
    assign w_div0      = w_accept && is_div(w_op) && (bus.b == '0);
    assign w_start_div = w_accept && is_div(w_op) && (bus.b != '0);
    assign w_signed    = (w_op == EXE_ALU_MULT) || (w_op == EXE_ALU_DIV);
    assign w_run       = (r_state == ST_MUL) || (r_state == ST_DIV);
`else
    assign w_signed    = (w_op == EXE_ALU_MULT);
    assign w_run       = (r_state == ST_MUL);
`endif

    always_comb begin
        w_alu = '0;
        unique case (w_op)
            EXE_ALU_ADD:  w_alu = bus.a + bus.b;
            EXE_ALU_SUB:  w_alu = bus.a - bus.b;
            EXE_ALU_SLT:  w_alu = {{(WIDTH-1){1'b0}},
                                   $signed(bus.a) < $signed(bus.b)};
            EXE_ALU_AND:  w_alu = bus.a & bus.b;
            EXE_ALU_OR:   w_alu = bus.a | bus.b;
            EXE_ALU_SLL:  w_alu = bus.b << w_sh;
            EXE_ALU_SRL:  w_alu = bus.b >> w_sh;
            EXE_ALU_LUI:  w_alu = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            EXE_ALU_XOR:  w_alu = bus.a ^ bus.b;
            EXE_ALU_NOR:  w_alu = ~(bus.a | bus.b);
            EXE_ALU_SLTU: w_alu = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
            EXE_ALU_SRA:  w_alu = $unsigned($signed(bus.b) >>> w_sh);
            EXE_ALU_MULT, EXE_ALU_MULTU,
            EXE_ALU_DIV, EXE_ALU_DIVU: w_alu = '0;
        endcase
    end

    always_comb begin
        w_state_n = r_state;
        if (bus.flush) begin
            w_state_n = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start_mul) w_state_n = ST_MUL;
`ifdef ALU_MDU_DIV_EN
                    if (w_start_div) w_state_n = ST_DIV;
                    if (w_div0)      w_state_n = ST_DONE;
`endif
                end
                ST_MUL:  if (w_last) w_state_n = ST_FIX;
`ifdef ALU_MDU_DIV_EN
                ST_DIV:  if (w_last) w_state_n = ST_FIX;
`endif
                ST_FIX:  w_state_n = ST_DONE;
                ST_DONE: w_state_n = ST_IDLE;
                default: w_state_n = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            r_state     <= w_state_n;
            r_out_valid <= 1'b0;
            if (w_single) begin
                r_out_valid <= 1'b1;
                r_result    <= w_alu;
            end
`ifdef ALU_MDU_DIV_EN
            if (w_div0) begin
                r_out_valid <= 1'b1;
                r_result    <= '1;
                r_lo        <= '1;
                r_hi        <= bus.a;
            end
`endif
            // a flush during FIX must not commit HI/LO
            if ((r_state == ST_FIX) && !bus.flush) begin
                r_out_valid <= 1'b1;
                r_result    <= w_fix_lo;
                r_hi        <= w_fix_hi;
                r_lo        <= w_fix_lo;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;
    assign bus.busy      = (r_state != ST_IDLE);

    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start_mul (w_start_mul),
`ifdef ALU_MDU_DIV_EN
        .i_start_div (w_start_div),
`endif
        .i_signed    (w_signed),
        .i_run       (w_run),
        .i_a         (bus.a),
        .i_b         (bus.b),
        .o_last      (w_last),
        .o_hi        (w_fix_hi),
        .o_lo        (w_fix_lo)
    );
endmodule
